// File: rtl/stopwatch_lap_ctrl_if.sv
// rtl/stopwatch_lap_ctrl_if.sv - command, counter and lap-buffer signals of the stopwatch controller
interface stopwatch_lap_ctrl_if;
    logic       start;
    logic       stop;
    logic       lap;
    logic       clear;
    logic       lap_rd;
    logic [7:0] minute;
    logic [5:0] seconds;
    logic       enable;
    logic       counter_clear;
    logic [1:0] state;
    logic       lap_valid;
    logic [7:0] lap_minute;
    logic [5:0] lap_seconds;
    logic [2:0] lap_count;
    logic       lap_overflow;

    modport master (
        output start, stop, lap, clear, lap_rd, minute, seconds,
        input  enable, counter_clear, state, lap_valid, lap_minute, lap_seconds,
               lap_count, lap_overflow
    );

    modport slave (
        input  start, stop, lap, clear, lap_rd, minute, seconds,
        output enable, counter_clear, state, lap_valid, lap_minute, lap_seconds,
               lap_count, lap_overflow
    );
endinterface

// File: rtl/stopwatch_lap_ctrl.sv
// rtl/stopwatch_lap_ctrl.sv - stopwatch run/pause FSM, seconds prescaler and 4-entry lap FIFO
module stopwatch_lap_ctrl #(
    parameter int TICK_DIV  = 100000000,
    parameter int LAP_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    stopwatch_lap_ctrl_if.slave  bus
);
    localparam int             PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  TERM = PW'(TICK_DIV - 1);
    localparam logic [2:0]     FULL = 3'(LAP_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSED = 2'b10
    } state_t;

    state_t        st;
    state_t        st_n;
    logic [PW-1:0] presc;
    logic          enable_q;
    logic          cclr_q;

    logic [13:0]   mem [0:3];
    logic [1:0]    wr_ptr;
    logic [1:0]    rd_ptr;
    logic [1:0]    rd_n;
    logic [2:0]    cnt;
    logic [2:0]    cnt_n;
    logic [13:0]   head_q;
    logic [13:0]   head_n;
    logic          ovf_q;
    logic          push;
    logic          pop;
    logic          do_wr;
    logic          ovf_set;

    // stop outranks start, clear outranks everything
    always_comb begin
        st_n = st;
        case (st)
            IDLE:    if (bus.start && !bus.stop) st_n = RUN;
            RUN:     if (bus.stop) st_n = PAUSED;
            PAUSED:  if (bus.start && !bus.stop) st_n = RUN;
            default: st_n = IDLE;
        endcase
        if (bus.clear) st_n = IDLE;
    end

    always_comb begin
        push    = bus.lap && (st == RUN) && !bus.clear;
        pop     = bus.lap_rd && (cnt != 3'd0) && !bus.clear;
        do_wr   = push && (pop || (cnt != FULL));
        ovf_set = push && !pop && (cnt == FULL);
        rd_n    = rd_ptr + {1'b0, pop};
        cnt_n   = cnt + {2'b00, do_wr} - {2'b00, pop};
        // show-ahead head: the entry written this cycle becomes the head when it lands at rd_n
        if (cnt_n == 3'd0)
            head_n = 14'd0;
        else if (do_wr && (wr_ptr == rd_n))
            head_n = {bus.minute, bus.seconds};
        else
            head_n = mem[rd_n];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st       <= IDLE;
            presc    <= '0;
            enable_q <= 1'b0;
            cclr_q   <= 1'b1;
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            cnt      <= 3'd0;
            head_q   <= 14'd0;
            ovf_q    <= 1'b0;
        end else begin
            st     <= st_n;
            cclr_q <= bus.clear;

            // a stop on the terminal count leaves presc at TERM so the second fires on resume
            if (bus.clear) begin
                presc    <= '0;
                enable_q <= 1'b0;
            end else if (st_n == RUN) begin
                if (presc == TERM) begin
                    presc    <= '0;
                    enable_q <= 1'b1;
                end else begin
                    presc    <= presc + 1'b1;
                    enable_q <= 1'b0;
                end
            end else begin
                enable_q <= 1'b0;
            end

            if (bus.clear) begin
                wr_ptr <= 2'd0;
                rd_ptr <= 2'd0;
                cnt    <= 3'd0;
                head_q <= 14'd0;
                ovf_q  <= 1'b0;
            end else begin
                wr_ptr <= wr_ptr + {1'b0, do_wr};
                rd_ptr <= rd_n;
                cnt    <= cnt_n;
                head_q <= head_n;
                if (ovf_set) ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_wr) mem[wr_ptr] <= {bus.minute, bus.seconds};
    end

    assign bus.state         = st;
    assign bus.enable        = enable_q;
    assign bus.counter_clear = cclr_q;
    assign bus.lap_count     = cnt;
    assign bus.lap_valid     = (cnt != 3'd0);
    assign bus.lap_minute    = head_q[13:6];
    assign bus.lap_seconds   = head_q[5:0];
    assign bus.lap_overflow  = ovf_q;
endmodule
